// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (LSB first, one start bit, one stop bit, no parity).
// The asynchronous line is brought in through a two-flop synchroniser. The start bit
// is confirmed at its mid-point, and data and stop bits are sampled at bit centres.
// Each received byte is presented in a one-entry holding register.
//
// Handshake: valid=1 means data_out holds a byte that has not been read yet. The
// consumer pulses rd_ack for one cycle to take it. On the next cycle valid, overrun
// and frame_err clear. An rd_ack while valid=0 clears only the two sticky flags. If
// a new byte is delivered in the same cycle as rd_ack, the new byte wins: valid
// stays 1 and both flags clear.
module uart_rx #(
   parameter int CLKS_PER_BIT = 1302,
   parameter int HALF_BIT     = 651
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd_in,
   input  logic       rd_ack,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       overrun,
   output logic       frame_err,
   output logic       busy,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_WAITH = 3'd4
   } state_t;

   // Terminal counts are reached one cycle before the sampling edge.
   localparam logic [10:0] HALF_LAST = 11'(HALF_BIT - 1);
   localparam logic [10:0] BIT_LAST  = 11'(CLKS_PER_BIT - 1);

   logic        sync_q1;
   logic        rxd_s;
   state_t      state;
   state_t      state_nxt;
   logic [10:0] cntr;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        deliver;
   logic        cntr_en;
   logic        cntr_clr;
   logic        take_bit;
   logic        take_stop;
   logic        frame_set;

   // Two-flop synchroniser. It resets to the idle (high) line level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= 1'b1;
         rxd_s   <= 1'b1;
      end else begin
         sync_q1 <= rxd_in;
         rxd_s   <= sync_q1;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and the sampling strobes.
   always_comb begin
      state_nxt = state;
      cntr_en   = 1'b0;
      take_bit  = 1'b0;
      take_stop = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rxd_s) begin
               state_nxt = S_START;
            end
         end
         S_START: begin
            cntr_en = 1'b1;
            if (cntr == HALF_LAST) begin
               // A line that is high again at mid-start was a glitch.
               state_nxt = rxd_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            cntr_en = 1'b1;
            if (cntr == BIT_LAST) begin
               take_bit = 1'b1;
               if (bit_idx == 3'd7) begin
                  state_nxt = S_STOP;
               end
            end
         end
         S_STOP: begin
            cntr_en = 1'b1;
            if (cntr == BIT_LAST) begin
               take_stop = 1'b1;
               // A low stop bit may be a break. Wait for the line to idle before
               // hunting for the next start edge.
               state_nxt = rxd_s ? S_IDLE : S_WAITH;
            end
         end
         S_WAITH: begin
            if (rxd_s) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      cntr_clr = (state_nxt != state) || take_bit;
   end

   // Bit timer: it restarts on every state change and every data-bit sample.
   always_ff @(posedge clk) begin
      if (rst || cntr_clr) begin
         cntr <= 11'd0;
      end else if (cntr_en) begin
         cntr <= cntr + 11'd1;
      end
   end

   // Data shift register: each bit lands in its own position, LSB first.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_idx <= 3'd0;
         shift   <= 8'h00;
      end else if (state == S_START && state_nxt == S_DATA) begin
         bit_idx <= 3'd0;
      end else if (take_bit) begin
         shift[bit_idx] <= rxd_s;
         bit_idx        <= bit_idx + 3'd1;
      end
   end

   assign frame_set = take_stop && !rxd_s;

   // A good stop bit schedules delivery of the byte on the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         deliver <= 1'b0;
      end else begin
         deliver <= take_stop && rxd_s;
      end
   end

   // Holding register, valid flag and overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= 8'h00;
         valid    <= 1'b0;
         overrun  <= 1'b0;
      end else if (deliver) begin
         data_out <= shift;
         valid    <= 1'b1;
         // An unread byte that is overwritten without an ack counts as an overrun.
         overrun  <= rd_ack ? 1'b0 : (overrun || valid);
      end else if (rd_ack) begin
         valid   <= 1'b0;
         overrun <= 1'b0;
      end
   end

   // Sticky framing error. A fresh error takes precedence over a clearing ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err <= 1'b0;
      end else if (frame_set) begin
         frame_err <= 1'b1;
      end else if (rd_ack) begin
         frame_err <= 1'b0;
      end
   end

   assign busy      = (state != S_IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. The DUT runs with a short bit period so the
// whole frame sequence stays small.
module tb_uart_rx;

   localparam int CPB  = 32;
   localparam int HALF = 16;
   // Pin start edge to the first cycle with valid=1: 2 synchroniser cycles + 1 cycle
   // to leave IDLE, HALF + 9*CPB cycles to the stop sample, then 1 cycle to deliver.
   localparam int LAT  = 3 + HALF + 9 * CPB + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd_in;
   logic       rd_ack;
   logic [7:0] data_out;
   logic       valid;
   logic       overrun;
   logic       frame_err;
   logic       busy;
   logic [2:0] state_dbg;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_q[$];

   // Clock and overall watchdog.
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
      .clk       (clk),
      .rst       (rst),
      .rxd_in    (rxd_in),
      .rd_ack    (rd_ack),
      .data_out  (data_out),
      .valid     (valid),
      .overrun   (overrun),
      .frame_err (frame_err),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // Driver: one complete frame. Call this just after a clock edge. It returns 1 time
   // unit after the last bit period, leaving the line at the stop level.
   task automatic send_byte(input logic [7:0] d, input logic stop_bit);
      rxd_in = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rxd_in = d[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      rxd_in = stop_bit;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   // Driver: one-cycle rd_ack pulse.
   task automatic pulse_ack();
      rd_ack = 1'b1;
      @(posedge clk);
      #1;
      rd_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      rxd_in = 1'b1;
      rd_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({data_out, valid, overrun, frame_err, busy} !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_outputs: got data=%h v=%b ov=%b fe=%b busy=%b want 00 0 0 0 0",
                  data_out, valid, overrun, frame_err, busy);
      end
      n_cmp++;
      if (state_dbg !== 3'd0) begin
         n_bad++;
         $display("FAIL reset_state: got %0d want 0", state_dbg);
      end
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_after_reset: got busy=%b valid=%b want 0 0", busy, valid);
      end
   endtask

   task automatic test_basic();
      int lat;
      logic got;
      logic [7:0] e;
      exp_q.push_back(8'hA5);
      lat = 0;
      got = 1'b0;
      fork
         send_byte(8'hA5, 1'b1);
         begin
            while (!got && lat < 400) begin
               @(posedge clk);
               #1;
               lat++;
               if (valid === 1'b1) got = 1'b1;
            end
         end
      join
      n_cmp++;
      if (lat != LAT) begin
         n_bad++;
         $display("FAIL basic_latency: got %0d cycles want %0d", lat, LAT);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (data_out !== e || valid !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_data: got %h v=%b want %h v=1", data_out, valid, e);
      end
      n_cmp++;
      if (overrun !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_flags: got ov=%b fe=%b busy=%b want 0 0 0", overrun, frame_err, busy);
      end
      pulse_ack();
      n_cmp++;
      if (valid !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_ack: got valid=%b want 0", valid);
      end
   endtask

   task automatic test_glitch();
      rxd_in = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rxd_in = 1'b1;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL glitch_busy_rise: got %b want 1", busy);
      end
      repeat (13) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL glitch_busy_hold: got %b want 1", busy);
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL glitch_busy_fall: got %b want 0", busy);
      end
      n_cmp++;
      if (valid !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
         n_bad++;
         $display("FAIL glitch_flags: got v=%b ov=%b fe=%b want 0 0 0", valid, overrun, frame_err);
      end
   endtask

   task automatic test_frame_err();
      send_byte(8'h3C, 1'b0);
      n_cmp++;
      if (frame_err !== 1'b1 || valid !== 1'b0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL ferr_set: got fe=%b v=%b busy=%b want 1 0 1", frame_err, valid, busy);
      end
      repeat (100) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b1 || state_dbg !== 3'd4) begin
         n_bad++;
         $display("FAIL ferr_hold_low: got busy=%b state=%0d want 1 4", busy, state_dbg);
      end
      rxd_in = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || frame_err !== 1'b1 || valid !== 1'b0) begin
         n_bad++;
         $display("FAIL ferr_release: got busy=%b fe=%b v=%b want 0 1 0", busy, frame_err, valid);
      end
      pulse_ack();
      n_cmp++;
      if (frame_err !== 1'b0) begin
         n_bad++;
         $display("FAIL ferr_ack: got %b want 0", frame_err);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e;
      exp_q.push_back(8'h55);
      send_byte(8'h55, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (data_out !== e || valid !== 1'b1 || overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_first: got %h v=%b ov=%b want %h 1 0", data_out, valid, overrun, e);
      end
      exp_q.push_back(8'hAA);
      send_byte(8'hAA, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (data_out !== e || valid !== 1'b1 || overrun !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_second: got %h v=%b ov=%b want %h 1 1", data_out, valid, overrun, e);
      end
      pulse_ack();
      n_cmp++;
      if (valid !== 1'b0 || overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_ack: got v=%b ov=%b want 0 0", valid, overrun);
      end
   endtask

   task automatic test_ack_on_delivery();
      logic [7:0] e;
      send_byte(8'h12, 1'b1);
      n_cmp++;
      if (data_out !== 8'h12 || valid !== 1'b1) begin
         n_bad++;
         $display("FAIL aod_first: got %h v=%b want 12 1", data_out, valid);
      end
      exp_q.push_back(8'h34);
      fork
         send_byte(8'h34, 1'b1);
         begin
            repeat (LAT - 1) @(posedge clk);
            #1;
            rd_ack = 1'b1;
            @(posedge clk);
            #1;
            rd_ack = 1'b0;
         end
      join
      e = exp_q.pop_front();
      n_cmp++;
      if (data_out !== e || valid !== 1'b1 || overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL aod_second: got %h v=%b ov=%b want %h 1 0", data_out, valid, overrun, e);
      end
      pulse_ack();
   endtask

   task automatic test_reset_mid();
      logic [7:0] e;
      // 0xF0: start plus bits 0..3 are low, and the line goes high at bit 4.
      rxd_in = 1'b0;
      repeat (5 * CPB) @(posedge clk);
      #1;
      rxd_in = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({data_out, valid, overrun, frame_err, busy} !== 12'h000 || state_dbg !== 3'd0) begin
         n_bad++;
         $display("FAIL midrst_outputs: got data=%h v=%b ov=%b fe=%b busy=%b st=%0d want all 0",
                  data_out, valid, overrun, frame_err, busy, state_dbg);
      end
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      exp_q.push_back(8'h0F);
      send_byte(8'h0F, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (data_out !== e || valid !== 1'b1 || overrun !== 1'b0 || frame_err !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_next: got %h v=%b ov=%b fe=%b want %h 1 0 0",
                  data_out, valid, overrun, frame_err, e);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_ack_on_delivery();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
